// File: rtl/regfile_op_sequencer.sv
// Four-state operation sequencer (IDLE/READ/EXEC/WB) driving an external
// 8-entry register file: read operands, execute one ALU op, write back.
module regfile_op_sequencer #(
    parameter int N = 8,
    parameter int A = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [2:0]   op,
    input  logic [A-1:0] rd,
    input  logic [A-1:0] rs1,
    input  logic [A-1:0] rs2,
    input  logic [N-1:0] imm,
    output logic [A-1:0] ra1,
    output logic [A-1:0] ra2,
    input  logic [N-1:0] rd1,
    input  logic [N-1:0] rd2,
    output logic [A-1:0] wa3,
    output logic [N-1:0] wd3,
    output logic         we3,
    output logic         done,
    output logic         flag_z,
    output logic         flag_c
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    state_t       state_r;
    state_t       state_next_s;
    logic         accept_s;
    logic [2:0]   op_r;
    logic [N-1:0] imm_r;
    logic [N-1:0] opa_r;
    logic [N-1:0] opb_r;
    logic [N:0]   alu_s;

    // Bit N carries the carry-out for ADD/ADDI and the borrow for SUB.
    function automatic logic [N:0] alu(input logic [2:0] f_op, input logic [N-1:0] a,
                                       input logic [N-1:0] b, input logic [N-1:0] k);
        logic [N:0] r;
        case (f_op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_ADDI: r = {1'b0, a} + {1'b0, k};
            OP_LI:   r = {1'b0, k};
            default: r = {(N+1){1'b0}};
        endcase
        return r;
    endfunction

    assign accept_s = instr_valid && (state_r == IDLE);
    assign alu_s    = alu(op_r, opa_r, opb_r, imm_r);

    // Next-state decode for the fixed one-cycle-per-state sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ:    state_next_s = EXEC;
            EXEC:    state_next_s = WB;
            WB:      state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, latched fields, operands, result and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            instr_ready <= 1'b1;
            op_r        <= 3'b000;
            imm_r       <= {N{1'b0}};
            opa_r       <= {N{1'b0}};
            opb_r       <= {N{1'b0}};
            ra1         <= {A{1'b0}};
            ra2         <= {A{1'b0}};
            wa3         <= {A{1'b0}};
            wd3         <= {N{1'b0}};
            we3         <= 1'b0;
            done        <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            instr_ready <= (state_next_s == IDLE);
            we3         <= 1'b0;
            done        <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r  <= op;
                        imm_r <= imm;
                        ra1   <= rs1;
                        ra2   <= rs2;
                        wa3   <= rd;
                    end
                end
                READ: begin
                    opa_r <= rd1;
                    opb_r <= rd2;
                end
                EXEC: begin
                    done <= 1'b1;
                    // NOP keeps the previous result and flags visible.
                    if (op_r != OP_NOP) begin
                        we3    <= 1'b1;
                        wd3    <= alu_s[N-1:0];
                        flag_c <= alu_s[N];
                        flag_z <= (alu_s[N-1:0] == {N{1'b0}});
                    end
                end
                WB: begin
                    we3 <= 1'b0;
                end
                default: begin
                    we3 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench: driver issues instructions and queues expected writebacks
// from an arithmetic reference model; a negedge monitor checks each done pulse.
module tb_regfile_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic [2:0] ra1, ra2, wa3;
    logic [7:0] rd1, rd2, wd3;
    logic       we3, done, flag_z, flag_c;

    regfile_op_sequencer #(.N(8), .A(3)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wa3(wa3), .wd3(wd3), .we3(we3), .done(done), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    // Register file attached to the sequencer; it has no reset.
    logic [7:0] rf [8];
    initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    always @(posedge clk) if (we3) rf[wa3] <= wd3;
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: architectural register contents, flags, last result.
    typedef struct { int cyc; int wa; int wd; int we; int z; int c; } exp_t;
    exp_t sbq[$];
    int   ref_rf [8];
    int   ref_z = 0, ref_c = 0, ref_last = 0;

    function automatic void model(input int f_op, input int f_rd, input int f_rs1,
                                  input int f_rs2, input int f_imm, input int acc);
        int a, b, res, c;
        exp_t e;
        a = ref_rf[f_rs1];
        b = ref_rf[f_rs2];
        c = 0;
        res = 0;
        case (f_op)
            0: begin res = a + b;     c = (res > 255); end
            1: begin res = a - b;     c = (a < b);     end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = a + f_imm; c = (res > 255); end
            6: res = f_imm;
            default: res = 0;
        endcase
        res = res & 255;
        if (f_op != 7) begin
            ref_rf[f_rd] = res;
            ref_z = (res == 0);
            ref_c = c;
            ref_last = res;
        end
        e.cyc = acc + 3;
        e.wa  = f_rd;
        e.wd  = ref_last;
        e.we  = (f_op != 7);
        e.z   = ref_z;
        e.c   = ref_c;
        sbq.push_back(e);
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("wa3", int'(wa3), e.wa);
                    chk("wd3", int'(wd3), e.wd);
                    chk("we3", int'(we3), e.we);
                    chk("flag_z", int'(flag_z), e.z);
                    chk("flag_c", int'(flag_c), e.c);
                end
            end else if (we3) begin
                chk("we3_without_done", 1, 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input int f_op, input int f_rd, input int f_rs1, input int f_rs2,
                         input int f_imm, input bit hold, input bit track, output int acc);
        int waited = 0;
        while (!instr_ready && waited < 20) begin
            if (instr_valid) begin
                op = 3'($urandom); rd = 3'($urandom); rs1 = 3'($urandom);
                rs2 = 3'($urandom); imm = 8'($urandom);
            end
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) chk("ready_timeout", 0, 1);
        op = 3'(f_op); rd = 3'(f_rd); rs1 = 3'(f_rs1); rs2 = 3'(f_rs2); imm = 8'(f_imm);
        instr_valid = 1'b1;
        acc = cyc;
        if (track) model(f_op, f_rd, f_rs1, f_rs2, f_imm, acc);
        @(negedge clk);
        chk("ra1_in_read", int'(ra1), f_rs1);
        chk("ra2_in_read", int'(ra2), f_rs2);
        chk("ready_busy", int'(instr_ready), 0);
        if (hold) begin
            op = 3'($urandom); rd = 3'($urandom); rs1 = 3'($urandom);
            rs2 = 3'($urandom); imm = 8'($urandom);
        end else begin
            instr_valid = 1'b0;
        end
    endtask

    initial begin
        int a1, a2, n;
        for (int i = 0; i < 8; i++) ref_rf[i] = 0;
        rst = 1'b1; instr_valid = 1'b0;
        op = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0; imm = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(instr_ready), 1);
        chk("rst_we3", int'(we3), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", int'({flag_z, flag_c}), 0);
        chk("rst_addr", int'({ra1, ra2, wa3}), 0);
        chk("rst_wd3", int'(wd3), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed: LI, ADD with carry, SUB zero/borrow, ADDI wrap.
        issue(6, 1, 0, 0, 8'hAB, 0, 1, a1);
        issue(6, 4, 0, 0, 8'h5C, 0, 1, a1);
        issue(0, 2, 1, 4, 0, 0, 1, a1);
        issue(1, 3, 4, 4, 0, 0, 1, a1);
        issue(1, 5, 4, 1, 0, 0, 1, a1);
        issue(5, 6, 1, 0, 8'h55, 0, 1, a1);

        // Handshake: valid held high with noise on the fields while busy.
        issue(6, 7, 0, 0, 8'h11, 1, 1, a1);
        issue(4, 6, 7, 1, 0, 0, 1, a2);
        chk("issue_gap", a2 - a1, 4);

        // NOP after ADD keeps C=1/Z=0 and never writes.
        issue(0, 2, 1, 4, 0, 0, 1, a1);
        issue(7, 5, 0, 0, 0, 0, 1, a1);
        repeat (4) @(negedge clk);
        chk("nop_flag_c", int'(flag_c), 1);
        chk("nop_flag_z", int'(flag_z), 0);
        chk("nop_r5_kept", int'(rf[5]), ref_rf[5]);

        // Reset during EXEC of ADD r2,r1,r4: no write, no done, flags cleared.
        issue(0, 2, 1, 4, 0, 0, 0, a1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_we3", int'(we3), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_flags", int'({flag_z, flag_c}), 0);
        chk("midrst_ready", int'(instr_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_z = 0; ref_c = 0; ref_last = 0;
        @(negedge clk);
        chk("midrst_r2", int'(rf[2]), 8'h07);
        chk("post_rst_ready", int'(instr_ready), 1);
        issue(5, 0, 2, 0, 0, 0, 1, a1);

        // Randomized traffic, occasionally holding valid across instructions.
        for (int k = 0; k < 80; k++) begin
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 1, a1);
        end
        instr_valid = 1'b0;

        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", sbq.size(), 0);
        for (int i = 0; i < 8; i++) chk("final_reg", int'(rf[i]), ref_rf[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
